// File: rtl/hawk_axi_wr_downsizer.sv
// AXI write-channel downsizer: splits 512-bit cacheline write beats into two
// 256-bit beats (lower half first) and rescales AW bursts to match.
module hawk_axi_wr_downsizer #(
  parameter int ADDR_W   = 64,
  parameter int ID_W     = 6,
  parameter int S_DATA_W = 512,
  parameter int M_DATA_W = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ID_W-1:0]       s_axi_awid,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,

  input  logic [S_DATA_W-1:0]   s_axi_wdata,
  input  logic [S_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,

  output logic [ID_W-1:0]       s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,

  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [M_DATA_W-1:0]   m_axi_wdata,
  output logic [M_DATA_W/8-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic                  err_o
);

  localparam int M_STRB_W = M_DATA_W / 8;
  localparam int S_STRB_W = S_DATA_W / 8;

  logic              aw_full;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [1:0]        aw_burst;
  logic              aw_accept;
  logic              err_q;

  logic                w_full;
  logic                half;
  logic [S_DATA_W-1:0] w_data;
  logic [S_STRB_W-1:0] w_strb;
  logic                w_last;
  logic                w_accept;
  logic                m_w_hs;

  // AW stage: a single skid-free register that can reload in the cycle it drains.
  assign s_axi_awready = !aw_full || m_axi_awready;
  assign aw_accept     = s_axi_awvalid && s_axi_awready;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full <= 1'b0;
    end else if (aw_accept) begin
      aw_full <= 1'b1;
    end else if (m_axi_awready) begin
      aw_full <= 1'b0;
    end
  end

  // Each slave beat becomes two master beats, so the burst length is 2*len+1.
  always_ff @(posedge clk) begin
    if (aw_accept) begin
      aw_id    <= s_axi_awid;
      aw_addr  <= s_axi_awaddr;
      aw_len   <= {s_axi_awlen[6:0], 1'b1};
      aw_burst <= s_axi_awburst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (aw_accept && (s_axi_awlen[7] || (s_axi_awsize != 3'd6))) begin
      err_q <= 1'b1;
    end
  end

  assign m_axi_awid    = aw_id;
  assign m_axi_awaddr  = aw_addr;
  assign m_axi_awlen   = aw_len;
  assign m_axi_awsize  = 3'd5;
  assign m_axi_awburst = aw_burst;
  assign m_axi_awvalid = aw_full;
  assign err_o         = err_q;

  // W stage: accepting during the upper-half handshake keeps the master side bubble-free.
  assign s_axi_wready = !w_full || (half && m_axi_wready);
  assign w_accept     = s_axi_wvalid && s_axi_wready;
  assign m_w_hs       = w_full && m_axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_full <= 1'b0;
      half   <= 1'b0;
    end else if (w_accept) begin
      w_full <= 1'b1;
      half   <= 1'b0;
    end else if (m_w_hs) begin
      if (half) begin
        w_full <= 1'b0;
        half   <= 1'b0;
      end else begin
        half   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      w_data <= s_axi_wdata;
      w_strb <= s_axi_wstrb;
      w_last <= s_axi_wlast;
    end
  end

  assign m_axi_wdata  = half ? w_data[S_DATA_W-1:M_DATA_W] : w_data[M_DATA_W-1:0];
  assign m_axi_wstrb  = half ? w_strb[S_STRB_W-1:M_STRB_W] : w_strb[M_STRB_W-1:0];
  assign m_axi_wlast  = w_last && half;
  assign m_axi_wvalid = w_full;

  assign s_axi_bid    = m_axi_bid;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_bvalid = m_axi_bvalid;
  assign m_axi_bready = s_axi_bready;

endmodule

// File: tb/tb_hawk_axi_wr_downsizer.sv
// Randomized bench for hawk_axi_wr_downsizer; a queue-based model predicts the
// master AW/W streams from what the slave side hands over.
module tb_hawk_axi_wr_downsizer;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
  } wbeat_t;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]   s_axi_awid;
  logic [63:0]  s_axi_awaddr;
  logic [7:0]   s_axi_awlen;
  logic [2:0]   s_axi_awsize;
  logic [1:0]   s_axi_awburst;
  logic         s_axi_awvalid, s_axi_awready;
  logic [511:0] s_axi_wdata;
  logic [63:0]  s_axi_wstrb;
  logic         s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [5:0]   s_axi_bid;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid, s_axi_bready;
  logic [5:0]   m_axi_awid;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid, m_axi_awready;
  logic [255:0] m_axi_wdata;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [5:0]   m_axi_bid;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic         err_o;

  hawk_axi_wr_downsizer dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_mode = 0;  // 0 always ready, 1 random, 2 held low, 3 driven by the test
  int aw_mode = 0;  // 0 always ready, 1 random, 2 held low
  int s_w_cnt = 0;
  int m_w_cnt = 0;

  wbeat_t exp_w[$];
  aw_t    exp_aw[$];
  wbeat_t m_w_log[$];
  aw_t    m_aw_log[$];
  int     s_w_stamp[$];
  int     m_w_stamp[$];

  wbeat_t got_w, e_w, w_hold_val;
  aw_t    got_aw, e_aw, aw_hold_val;
  logic   w_held = 1'b0;
  logic   aw_held = 1'b0;

  always @(posedge clk) cyc++;

  // Master-side ready generators, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (wr_mode)
        0: m_axi_wready = 1'b1;
        1: m_axi_wready = ($urandom % 3) != 0;
        2: m_axi_wready = 1'b0;
        default: ;
      endcase
      case (aw_mode)
        0: m_axi_awready = 1'b1;
        1: m_axi_awready = ($urandom % 2) != 0;
        default: m_axi_awready = 1'b0;
      endcase
    end
  end

  // Reference model and monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      w_held  = 1'b0;
      aw_held = 1'b0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        e_aw.id    = s_axi_awid;
        e_aw.addr  = s_axi_awaddr;
        e_aw.len   = 8'((2 * int'(s_axi_awlen) + 1) % 256);
        e_aw.size  = 3'd5;
        e_aw.burst = s_axi_awburst;
        exp_aw.push_back(e_aw);
      end
      if (s_axi_wvalid && s_axi_wready) begin
        e_w.data = s_axi_wdata[255:0];
        e_w.strb = s_axi_wstrb[31:0];
        e_w.last = 1'b0;
        exp_w.push_back(e_w);
        e_w.data = s_axi_wdata[511:256];
        e_w.strb = s_axi_wstrb[63:32];
        e_w.last = s_axi_wlast;
        exp_w.push_back(e_w);
        s_w_stamp.push_back(cyc);
        s_w_cnt++;
      end
      got_w  = {m_axi_wdata, m_axi_wstrb, m_axi_wlast};
      got_aw = {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst};
      if (m_axi_wvalid && m_axi_wready) begin
        checks++;
        if (exp_w.size() == 0) begin
          failures++;
          $display("[TB] FAIL w_beat unexpected got=%h", got_w);
        end else begin
          e_w = exp_w.pop_front();
          if (got_w !== e_w) begin
            failures++;
            $display("[TB] FAIL w_beat got=%h exp=%h", got_w, e_w);
          end
        end
        m_w_log.push_back(got_w);
        m_w_stamp.push_back(cyc);
        m_w_cnt++;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        checks++;
        if (exp_aw.size() == 0) begin
          failures++;
          $display("[TB] FAIL aw_beat unexpected got=%h", got_aw);
        end else begin
          e_aw = exp_aw.pop_front();
          if (got_aw !== e_aw) begin
            failures++;
            $display("[TB] FAIL aw_beat got=%h exp=%h", got_aw, e_aw);
          end
        end
        m_aw_log.push_back(got_aw);
      end
      if (w_held) begin
        checks++;
        if (m_axi_wvalid !== 1'b1 || got_w !== w_hold_val) begin
          failures++;
          $display("[TB] FAIL w_stable valid=%b got=%h held=%h", m_axi_wvalid, got_w, w_hold_val);
        end
      end
      if (aw_held) begin
        checks++;
        if (m_axi_awvalid !== 1'b1 || got_aw !== aw_hold_val) begin
          failures++;
          $display("[TB] FAIL aw_stable valid=%b got=%h held=%h", m_axi_awvalid, got_aw, aw_hold_val);
        end
      end
      w_held      = m_axi_wvalid && !m_axi_wready;
      w_hold_val  = got_w;
      aw_held     = m_axi_awvalid && !m_axi_awready;
      aw_hold_val = got_aw;
    end
  end

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_aw(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_awready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_axi_awready) begin
      failures++;
      $display("[TB] FAIL aw_accept_timeout got=%b exp=1", s_axi_awready);
    end
    step();
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [511:0] d, input logic [63:0] s, input logic l);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = l; s_axi_wvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_wready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_axi_wready) begin
      failures++;
      $display("[TB] FAIL w_accept_timeout got=%b exp=1", s_axi_wready);
    end
    step();
    s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_w.size() != 0 || exp_aw.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_w.size() != 0 || exp_aw.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain w_left=%0d aw_left=%0d exp=0", name, exp_w.size(), exp_aw.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_w.delete();
    exp_aw.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({s_axi_awready, s_axi_wready, m_axi_awvalid, m_axi_wvalid, err_o} !== 5'b11000) begin
      failures++;
      $display("[TB] FAIL reset_state got=%b exp=11000",
               {s_axi_awready, s_axi_wready, m_axi_awvalid, m_axi_wvalid, err_o});
    end
    for (int i = 0; i < 4; i++) begin
      m_axi_bid = 6'($urandom); m_axi_bresp = 2'($urandom);
      m_axi_bvalid = 1'($urandom); s_axi_bready = 1'($urandom);
      #1;
      checks++;
      if ({s_axi_bid, s_axi_bresp, s_axi_bvalid, m_axi_bready} !==
          {m_axi_bid, m_axi_bresp, m_axi_bvalid, s_axi_bready}) begin
        failures++;
        $display("[TB] FAIL b_passthru got=%h exp=%h", {s_axi_bid, s_axi_bresp, s_axi_bvalid, m_axi_bready},
                 {m_axi_bid, m_axi_bresp, m_axi_bvalid, s_axi_bready});
      end
    end
    m_axi_bvalid = 1'b0;
    step();
    rst = 1'b0;
    exp_w.delete();
    exp_aw.delete();
  endtask

  task automatic test_single();
    aw_t    want_aw;
    wbeat_t want0, want1;
    wr_mode = 0; aw_mode = 0;
    m_w_log.delete(); m_aw_log.delete();
    fork
      send_aw(6'd3, 64'h8000_0040, 8'd0, 3'd6, 2'd1);
      send_w({{32{8'hBB}}, {32{8'hAA}}}, {64{1'b1}}, 1'b1);
    join
    wait_drain("single", 50);
    want_aw = {6'd3, 64'h8000_0040, 8'd1, 3'd5, 2'd1};
    want0 = {{32{8'hAA}}, 32'hFFFF_FFFF, 1'b0};
    want1 = {{32{8'hBB}}, 32'hFFFF_FFFF, 1'b1};
    checks++;
    if (m_aw_log.size() != 1 || m_aw_log[0] !== want_aw) begin
      failures++;
      $display("[TB] FAIL single_aw count=%0d exp=1 got=%h want=%h", m_aw_log.size(),
               (m_aw_log.size() > 0) ? m_aw_log[0] : '0, want_aw);
    end
    checks++;
    if (m_w_log.size() != 2) begin
      failures++;
      $display("[TB] FAIL single_w_count got=%0d exp=2", m_w_log.size());
    end else begin
      checks++;
      if (m_w_log[0] !== want0 || m_w_log[1] !== want1) begin
        failures++;
        $display("[TB] FAIL single_w_order got0=%h got1=%h exp0=%h exp1=%h",
                 m_w_log[0], m_w_log[1], want0, want1);
      end
    end
    m_axi_bid = 6'd3; m_axi_bresp = 2'd0; m_axi_bvalid = 1'b1; s_axi_bready = 1'b1;
    #1;
    checks++;
    if ({s_axi_bvalid, s_axi_bid, s_axi_bresp, m_axi_bready} !== {1'b1, 6'd3, 2'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL single_b got=%h exp=%h", {s_axi_bvalid, s_axi_bid, s_axi_bresp, m_axi_bready},
               {1'b1, 6'd3, 2'd0, 1'b1});
    end
    s_axi_bready = 1'b0;
    #1;
    checks++;
    if (m_axi_bready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_bready got=%b exp=0", m_axi_bready);
    end
    m_axi_bvalid = 1'b0;
    step();
  endtask

  task automatic test_burst();
    wr_mode = 0; aw_mode = 0;
    s_w_stamp.delete(); m_w_stamp.delete(); m_aw_log.delete(); m_w_log.delete();
    fork
      send_aw(6'd5, {$urandom, $urandom}, 8'd3, 3'd6, 2'd1);
      for (int b = 0; b < 4; b++) send_w(rand512(), {64{1'b1}}, b == 3);
    join
    wait_drain("burst", 50);
    checks++;
    if (m_aw_log.size() != 1 || m_aw_log[0].len !== 8'd7) begin
      failures++;
      $display("[TB] FAIL burst_awlen got=%0d exp=7", (m_aw_log.size() > 0) ? m_aw_log[0].len : 8'd0);
    end
    checks++;
    if (s_w_stamp.size() != 4 || m_w_stamp.size() != 8) begin
      failures++;
      $display("[TB] FAIL burst_counts got=%0d/%0d exp=4/8", s_w_stamp.size(), m_w_stamp.size());
    end else begin
      checks++;
      if (m_w_stamp[0] != s_w_stamp[0] + 1) begin
        failures++;
        $display("[TB] FAIL burst_latency got=%0d exp=1", m_w_stamp[0] - s_w_stamp[0]);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (s_w_stamp[i] - s_w_stamp[i-1] != 2) begin
          failures++;
          $display("[TB] FAIL burst_s_spacing got=%0d exp=2", s_w_stamp[i] - s_w_stamp[i-1]);
        end
      end
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (m_w_stamp[i] - m_w_stamp[i-1] != 1) begin
          failures++;
          $display("[TB] FAIL burst_m_spacing got=%0d exp=1", m_w_stamp[i] - m_w_stamp[i-1]);
        end
      end
      checks++;
      if (m_w_log[7].last !== 1'b1 || m_w_log[6].last !== 1'b0) begin
        failures++;
        $display("[TB] FAIL burst_wlast got=%b%b exp=01", m_w_log[6].last, m_w_log[7].last);
      end
    end
  endtask

  task automatic test_w_before_aw();
    logic [63:0] addr;
    addr = {$urandom, $urandom};
    wr_mode = 0; aw_mode = 2;
    step();
    send_w(rand512(), {$urandom, $urandom}, 1'b1);
    repeat (4) step();
    checks++;
    if (exp_w.size() != 0 || m_axi_awvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL w_first_forward w_left=%0d awvalid=%b exp=0/0", exp_w.size(), m_axi_awvalid);
    end
    send_aw(6'd9, addr, 8'd0, 3'd6, 2'd1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({m_axi_awvalid, s_axi_awready, m_axi_awid, m_axi_awaddr} !== {1'b1, 1'b0, 6'd9, addr}) begin
        failures++;
        $display("[TB] FAIL aw_hold got=%h exp=%h", {m_axi_awvalid, s_axi_awready, m_axi_awid, m_axi_awaddr},
                 {1'b1, 1'b0, 6'd9, addr});
      end
    end
    step();
    aw_mode = 0;
    wait_drain("w_before_aw", 50);
  endtask

  task automatic test_backpressure();
    logic [7:0] lens[50];
    int total = 0;
    for (int i = 0; i < 50; i++) begin
      lens[i] = 8'($urandom_range(0, 7));
      total += int'(lens[i]) + 1;
    end
    s_w_cnt = 0; m_w_cnt = 0;
    wr_mode = 1; aw_mode = 1;
    fork
      for (int i = 0; i < 50; i++) begin
        send_aw(6'($urandom), {$urandom, $urandom}, lens[i], 3'd6, 2'($urandom_range(0, 2)));
        if ($urandom % 3 == 0) step();
      end
      for (int i = 0; i < 50; i++) begin
        for (int b = 0; b <= int'(lens[i]); b++) begin
          send_w(rand512(), {$urandom, $urandom}, b == int'(lens[i]));
          if ($urandom % 4 == 0) step();
        end
      end
    join
    wr_mode = 0; aw_mode = 0;
    wait_drain("backpressure", 2000);
    checks++;
    if (s_w_cnt != total || m_w_cnt != 2 * total) begin
      failures++;
      $display("[TB] FAIL bp_beat_count got=%0d/%0d exp=%0d/%0d", s_w_cnt, m_w_cnt, total, 2 * total);
    end
  endtask

  task automatic test_err();
    do_reset();
    send_aw(6'd1, 64'h1000, 8'd2, 3'd6, 2'd1);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_clean got=%b exp=0", err_o);
    end
    step();
    send_aw(6'd2, 64'h2000, 8'h80, 3'd6, 2'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (err_o !== 1'b1) begin
        failures++;
        $display("[TB] FAIL err_len_sticky cycle=%0d got=%b exp=1", i, err_o);
      end
    end
    step();
    wait_drain("err_len", 50);
    do_reset();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_reset got=%b exp=0", err_o);
    end
    send_aw(6'd4, 64'h3000, 8'd0, 3'd5, 2'd1);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL err_size got=%b exp=1", err_o);
    end
    step();
    wait_drain("err_size", 50);
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [511:0] d1, d2;
    d1 = rand512();
    d2 = rand512();
    wr_mode = 3;
    m_axi_wready = 1'b0;
    send_w(d1, {64{1'b1}}, 1'b1);
    m_axi_wready = 1'b1;
    step();
    m_axi_wready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== d1[511:256]) begin
      failures++;
      $display("[TB] FAIL mid_upper valid=%b got=%h exp=%h", m_axi_wvalid, m_axi_wdata, d1[511:256]);
    end
    step();
    rst = 1'b0;
    exp_w.delete();
    exp_aw.delete();
    @(negedge clk);
    checks++;
    if (m_axi_wvalid !== 1'b0 || s_axi_wready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset wvalid=%b wready=%b exp=0/1", m_axi_wvalid, s_axi_wready);
    end
    step();
    wr_mode = 0;
    send_w(d2, {64{1'b1}}, 1'b1);
    @(negedge clk);
    checks++;
    if (m_axi_wdata !== d2[255:0]) begin
      failures++;
      $display("[TB] FAIL mid_restart_lower got=%h exp=%h", m_axi_wdata, d2[255:0]);
    end
    step();
    wait_drain("reset_mid", 50);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
    step();
    test_reset();
    test_single();
    test_burst();
    test_w_before_aw();
    test_backpressure();
    test_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hawk_axi_wr_downsizer.md
# hawk_axi_wr_downsizer

Write-channel width converter between the HAWK AXI crossbar output (512-bit cacheline beats) and the Genesys2 DDR memory controller write port (256-bit). Each 512-bit write beat is split into two 256-bit beats, lower half first. AW bursts are rescaled to match. B responses pass straight through. The block is registered on AW and W, and gives full master-side throughput with no bubbles between halves.

## Interface
Parameters:
- ADDR_W, 64, AXI address width
- ID_W, 6, AXI ID width
- S_DATA_W, 512, slave data width; fixed at 2×M_DATA_W
- M_DATA_W, 256, master (MC-side) data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axi_awid / awaddr / awlen / awsize / awburst  in  ID_W / ADDR_W / 8 / 3 / 2  slave AW payload
- s_axi_awvalid  in  1 ; s_axi_awready  out  1  slave AW handshake
- s_axi_wdata / wstrb / wlast  in  S_DATA_W / S_DATA_W/8 / 1  slave W payload
- s_axi_wvalid  in  1 ; s_axi_wready  out  1  slave W handshake
- s_axi_bid / bresp  out  ID_W / 2 ; s_axi_bvalid  out  1 ; s_axi_bready  in  1  slave B channel
- m_axi_awid / awaddr / awlen / awsize / awburst  out  ID_W / ADDR_W / 8 / 3 / 2  master AW payload
- m_axi_awvalid  out  1 ; m_axi_awready  in  1  master AW handshake
- m_axi_wdata / wstrb / wlast  out  M_DATA_W / M_DATA_W/8 / 1  master W payload
- m_axi_wvalid  out  1 ; m_axi_wready  in  1  master W handshake
- m_axi_bid / bresp  in  ID_W / 2 ; m_axi_bvalid  in  1 ; m_axi_bready  out  1  master B channel
- err_o  out  1  sticky protocol-error flag; cleared only by rst

## Operation
- AW stage: one-entry register (aw_full).
  - s_axi_awready = !aw_full || m_axi_awready.
  - On accept, the register loads: id, addr unchanged, m_awlen = {s_awlen[6:0],1'b1} (that is, 2·len+1), m_awsize = 3'd5, burst unchanged.
  - m_axi_awvalid = aw_full.
- W stage: one 512-bit holding register plus strb, last, w_full and a half pointer (0 = lower, 1 = upper).
  - Half 0 drives m_wdata = data[255:0] and m_wstrb = strb[31:0]. Half 1 drives data[511:256] and strb[63:32].
  - m_axi_wlast = last && half.
  - m_axi_wvalid = w_full.
  - On an m_axi_wready handshake with half 0: half becomes 1.
  - On an m_axi_wready handshake with half 1: half becomes 0, and w_full clears unless a new slave beat loads in the same cycle.
  - s_axi_wready = !w_full || (half && m_axi_wready). This allows a back-to-back reload with no bubble.
- AW and W are independent; W data may arrive before its AW. Relative order within each channel is preserved.
- B path is combinational pass-through: s_b* = m_b* and m_axi_bready = s_axi_bready. One slave AW maps to exactly one master burst, so there is exactly one B per burst.
- err_o sets on an accepted AW with s_awlen[7]=1 or s_awsize≠3'd6. The burst is still forwarded with the rule above; W beat-count consistency is then not guaranteed.
- All-zero strb halves are still forwarded; no beat is dropped.

## Timing
- Reset: s_axi_awready=1, s_axi_wready=1, m_axi_awvalid=0, m_axi_wvalid=0, half=0, err_o=0. B outputs follow their inputs.
- AW latency: slave accept at cycle N, so m_axi_awvalid=1 at N+1. Sustains 1 AW/cycle while m_axi_awready=1.
- W latency: slave beat accepted at N. Lower half is valid at N+1; upper half at N+2 if wready was high at N+1. With wready held high the next slave beat may be accepted at N+2, giving its lower half at N+3. Steady-state slave rate is one beat per 2 cycles and master rate is one beat per cycle.
- Backpressure: m_axi_wready low holds the current half and payload stable; valid is never dropped before its handshake.
- Reset asserted mid-burst discards the held AW and W state. half returns to 0 and partial bursts are not completed.

## Test plan
- Single write: AW addr=0x8000_0040, len=0, size=6, id=3, then W data={256'hB…, 256'hA…}, strb=all-ones, last=1. Required: m_awlen=1, m_awsize=5, addr unchanged; W beats A then B with wlast only on B; a B response with id=3 and OKAY is returned to the slave.
- Burst of len=3 with m_axi_wready=1 throughout. Required: m_awlen=7; 8 master beats on consecutive cycles, wlast on the 8th; s_axi_wready pattern 1,0,1,0…
- Random m_axi_wready backpressure over 50 bursts. Required: the master data stream equals the concatenated slave halves in order, payload stays stable while wvalid is high and wready is low, and there is no loss or duplication.
- W arriving 5 cycles before its AW, with m_axi_awready held low for 3 cycles. Required: W forwarded independently; AW held stable with s_axi_awready=0 while the register is full.
- AW with awlen=8'h80 or awsize=5. Required: err_o=1 from the next cycle, remaining 1 until rst.
- rst asserted between the two halves of a beat. Required: the next cycle shows m_axi_wvalid=0, s_axi_wready=1, and the following beat starts from the lower half.
